// File: rtl/rx_sync_pkg.sv
// rx_sync_pkg
// Shared definitions for the receive-side sync sequencer:
//   - state_e   : FSM state encoding (S_IDLE .. S_LOCKED)
//   - DEF_*     : default oversampling, counter width, settle/window lengths, lock threshold
//   - off_width : width of an index able to hold values 0..n-1 (never less than 1 bit)
package rx_sync_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_EVAL    = 3'd3,
    S_LOCKED  = 3'd4
  } state_e;

  localparam int unsigned DEF_OS     = 4;
  localparam int unsigned DEF_NB_CNT = 64;
  localparam int unsigned DEF_SETTLE = 16;
  localparam int unsigned DEF_WINDOW = 1024;
  localparam int unsigned DEF_THRESH = 0;

  // Bits needed to index n items.
  function automatic int unsigned off_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/strobe_counter.sv
// strobe_counter
// Loadable down-counter of baud strobes. A load arms the counter with the number of strobes the
// next phase needs; o_tc pulses in the cycle whose edge completes the phase.
// Ports:
//   clock, i_reset : clock and synchronous active-high reset
//   i_valid        : baud strobe
//   i_load         : arm with i_load_val (only issued while disarmed or on o_tc)
//   i_load_val     : strobes owed by the new phase
//   i_credit_en    : allow a strobe not owed to the current phase to count toward the loaded one
//   o_tc           : terminal pulse, the current phase has received all its strobes
module strobe_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_credit_en,
  output logic             o_tc
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;
  logic             armed_q, armed_d;
  logic             owed;
  logic             credit;

  // A strobe belongs to the running phase only while that phase still owes strobes; any other
  // strobe (e.g. one landing in EVAL) is handed to the phase being loaded.
  assign owed   = armed_q && (count_q != '0);
  assign credit = i_credit_en && i_valid && !owed;
  assign o_tc   = armed_q && ((count_q == '0) || (i_valid && (count_q == One)));

  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (i_load) begin
      armed_d = 1'b1;
      count_d = (credit && (i_load_val != '0)) ? i_load_val - One : i_load_val;
    end else if (armed_q) begin
      if (i_valid && (count_q != '0)) begin
        count_d = count_q - One;
      end
      if (o_tc) begin
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl
// Receive-side sampling-offset sequencer. Sweeps all OS offsets, measures the BER error-count
// delta over WINDOW strobes at each (after SETTLE strobes of resync), locks the offset with the
// fewest errors (ties keep the lower offset) and then keeps monitoring it window by window.
// Ports:
//   clock, i_reset    : clock and synchronous active-high reset
//   i_valid, i_start  : baud strobe; sweep request (honoured only in IDLE)
//   i_err_count       : cumulative error count from the BER block
//   o_offset          : sample buffer offset select
//   o_rx_enable       : RX/BER enable (everywhere except IDLE)
//   o_busy            : SETTLE, MEASURE or EVAL
//   o_locked          : last evaluated window was within THRESH
//   o_done, o_lost    : one-cycle pulses at sweep end / on loss of lock
//   o_best_err        : error delta of the chosen offset
module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int unsigned OS     = DEF_OS,
  parameter int unsigned NB_OFF = off_width(OS),
  parameter int unsigned NB_CNT = DEF_NB_CNT,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_start,
  input  logic [NB_CNT-1:0] i_err_count,
  output logic [NB_OFF-1:0] o_offset,
  output logic              o_rx_enable,
  output logic              o_busy,
  output logic              o_locked,
  output logic              o_done,
  output logic              o_lost,
  output logic [NB_CNT-1:0] o_best_err
);

  localparam int unsigned       CntMax    = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned       CntW      = off_width(CntMax + 1);
  localparam logic [CntW-1:0]   SettleVal = CntW'(SETTLE);
  localparam logic [CntW-1:0]   WindowVal = CntW'(WINDOW);
  localparam logic [NB_CNT-1:0] ThreshVal = NB_CNT'(THRESH);
  localparam logic [NB_OFF-1:0] LastCand  = NB_OFF'(OS - 1);
  localparam logic [NB_OFF-1:0] OffOne    = NB_OFF'(1);

  state_e            state_q, state_d;
  logic              mon_q, mon_d;            // EVAL is judging a monitor window, not a sweep step
  logic [NB_OFF-1:0] cand_q, cand_d;
  logic [NB_CNT-1:0] best_err_q, best_err_d;
  logic [NB_OFF-1:0] best_off_q, best_off_d;
  logic [NB_CNT-1:0] snap_q, snap_d;
  logic [NB_OFF-1:0] offset_q, offset_d;
  logic              rx_en_q, rx_en_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;
  logic              lost_q, lost_d;
  logic [NB_CNT-1:0] best_out_q, best_out_d;

  logic              cnt_load;
  logic [CntW-1:0]   cnt_val;
  logic              cnt_tc;
  logic              restart;

  // Modular subtraction absorbs a wrap of the cumulative counter.
  logic [NB_CNT-1:0] delta;
  logic              better;
  logic [NB_CNT-1:0] sweep_best;
  logic [NB_OFF-1:0] sweep_off;

  assign delta      = i_err_count - snap_q;
  assign better     = delta < best_err_q;
  assign sweep_best = better ? delta : best_err_q;
  assign sweep_off  = better ? cand_q : best_off_q;

  strobe_counter #(
    .Width(CntW)
  ) u_strobe_counter (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .i_credit_en(state_q != S_IDLE),
    .o_tc       (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    mon_d      = mon_q;
    cand_d     = cand_q;
    best_err_d = best_err_q;
    best_off_d = best_off_q;
    snap_d     = snap_q;
    offset_d   = offset_q;
    locked_d   = locked_q;
    best_out_d = best_out_q;
    done_d     = 1'b0;
    lost_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = SettleVal;
    restart    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          restart = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_tc) begin
          snap_d   = i_err_count;
          cnt_load = 1'b1;
          cnt_val  = WindowVal;
          state_d  = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (cnt_tc) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!mon_q) begin
          best_err_d = sweep_best;
          best_off_d = sweep_off;
          if (cand_q == LastCand) begin
            offset_d   = sweep_off;
            best_out_d = sweep_best;
            done_d     = 1'b1;
            locked_d   = (sweep_best <= ThreshVal);
            mon_d      = 1'b1;
            // Monitor windows chain back to back: the value judged here opens the next one.
            snap_d     = i_err_count;
            cnt_load   = 1'b1;
            cnt_val    = WindowVal;
            state_d    = S_LOCKED;
          end else begin
            cand_d   = cand_q + OffOne;
            offset_d = cand_q + OffOne;
            cnt_load = 1'b1;
            cnt_val  = SettleVal;
            state_d  = S_SETTLE;
          end
        end else if (delta <= ThreshVal) begin
          locked_d = 1'b1;
          snap_d   = i_err_count;
          cnt_load = 1'b1;
          cnt_val  = WindowVal;
          state_d  = S_LOCKED;
        end else begin
          lost_d   = 1'b1;
          locked_d = 1'b0;
          restart  = 1'b1;
        end
      end
      S_LOCKED: begin
        if (cnt_tc) begin
          state_d = S_EVAL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      cand_d     = '0;
      best_err_d = '1;
      best_off_d = '0;
      offset_d   = '0;
      mon_d      = 1'b0;
      cnt_load   = 1'b1;
      cnt_val    = SettleVal;
      state_d    = S_SETTLE;
    end

    rx_en_d = (state_d != S_IDLE);
    busy_d  = (state_d == S_SETTLE) || (state_d == S_MEASURE) || (state_d == S_EVAL);
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      mon_q      <= 1'b0;
      cand_q     <= '0;
      best_err_q <= '0;
      best_off_q <= '0;
      snap_q     <= '0;
      offset_q   <= '0;
      rx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      best_out_q <= '0;
    end else begin
      state_q    <= state_d;
      mon_q      <= mon_d;
      cand_q     <= cand_d;
      best_err_q <= best_err_d;
      best_off_q <= best_off_d;
      snap_q     <= snap_d;
      offset_q   <= offset_d;
      rx_en_q    <= rx_en_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
      best_out_q <= best_out_d;
    end
  end

  assign o_offset    = offset_q;
  assign o_rx_enable = rx_en_q;
  assign o_busy      = busy_q;
  assign o_locked    = locked_q;
  assign o_done      = done_q;
  assign o_lost      = lost_q;
  assign o_best_err  = best_out_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb_rx_sync_ctrl
// Directed and randomized bench for rx_sync_ctrl with OS=4, SETTLE=2, WINDOW=8, THRESH=0.
// Expected results come from a small model: best offset is the first minimum of the injected
// per-offset deltas, and phase timing is derived from strobe counts.
module tb_rx_sync_ctrl;

  localparam int unsigned OS     = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned WINDOW = 8;
  localparam int unsigned THRESH = 0;
  localparam int unsigned PH     = SETTLE + WINDOW;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_start;
  logic [63:0] i_err_count;
  logic [1:0]  o_offset;
  logic        o_rx_enable;
  logic        o_busy;
  logic        o_locked;
  logic        o_done;
  logic        o_lost;
  logic [63:0] o_best_err;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] dl [OS];
  int unsigned exp_off;
  logic [63:0] exp_best;

  rx_sync_ctrl #(
    .OS    (OS),
    .NB_OFF(2),
    .NB_CNT(64),
    .SETTLE(SETTLE),
    .WINDOW(WINDOW),
    .THRESH(THRESH)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_start    (i_start),
    .i_err_count(i_err_count),
    .o_offset   (o_offset),
    .o_rx_enable(o_rx_enable),
    .o_busy     (o_busy),
    .o_locked   (o_locked),
    .o_done     (o_done),
    .o_lost     (o_lost),
    .o_best_err (o_best_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic v, input logic st);
    i_valid = v;
    i_start = st;
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    i_reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_offset"}, 64'(o_offset), 64'd0);
    chk({tag, "_rx_en"}, 64'(o_rx_enable), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_locked"}, 64'(o_locked), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_lost"}, 64'(o_lost), 64'd0);
    chk({tag, "_best_err"}, o_best_err, 64'd0);
  endtask

  // First offset with the smallest delta wins.
  task automatic model_best();
    exp_best = '1;
    exp_off  = 0;
    for (int c = 0; c < OS; c++) begin
      if (dl[c] < exp_best) begin
        exp_best = dl[c];
        exp_off  = c;
      end
    end
  endtask

  // Full sweep with one strobe every 4 clocks; dl[c] errors land mid-window of offset c.
  task automatic sweep_p4(input logic [63:0] base);
    int unsigned c;
    int unsigned p;
    i_err_count = base;
    cyc(1'b0, 1'b1);
    chk("start_offset", 64'(o_offset), 64'd0);
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_rx_en", 64'(o_rx_enable), 64'd1);
    for (int s = 1; s <= int'(OS * PH); s++) begin
      c = (s - 1) / PH;
      p = (s - 1) % PH;
      cyc(1'b0, 1'b1);
      chk("walk_offset", 64'(o_offset), 64'(c));
      chk("walk_done", 64'(o_done), 64'd0);
      cyc(1'b0, 1'b0);
      if (p == SETTLE + 2) i_err_count = i_err_count + dl[c];
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
    model_best();
    cyc(1'b0, 1'b0);
    chk("sweep_done", 64'(o_done), 64'd1);
    chk("sweep_offset", 64'(o_offset), 64'(exp_off));
    chk("sweep_best_err", o_best_err, exp_best);
    chk("sweep_locked", 64'(o_locked), 64'(exp_best <= 64'(THRESH)));
    chk("sweep_busy", 64'(o_busy), 64'd0);
    cyc(1'b0, 1'b0);
    chk("done_width", 64'(o_done), 64'd0);
  endtask

  // One monitor window of WINDOW strobes, then the EVAL edge.
  task automatic mon_p4(input logic [63:0] errs);
    for (int k = 1; k <= int'(WINDOW); k++) begin
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      if (k == 3) i_err_count = i_err_count + errs;
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    i_reset     = 1'b1;
    i_valid     = 1'b0;
    i_start     = 1'b0;
    i_err_count = '0;

    // Reset state.
    do_reset();
    chk_reset_vals("reset");

    // Clean sweep, then a clean monitor window, then one error -> loss of lock.
    dl[0] = 64'd5; dl[1] = 64'd3; dl[2] = 64'd0; dl[3] = 64'd7;
    sweep_p4({$urandom, $urandom});
    mon_p4(64'd0);
    chk("mon_locked", 64'(o_locked), 64'd1);
    chk("mon_lost", 64'(o_lost), 64'd0);
    chk("mon_offset", 64'(o_offset), 64'd2);
    mon_p4(64'd1);
    chk("lost_pulse", 64'(o_lost), 64'd1);
    chk("lost_locked", 64'(o_locked), 64'd0);
    chk("lost_offset", 64'(o_offset), 64'd0);
    chk("lost_busy", 64'(o_busy), 64'd1);
    cyc(1'b0, 1'b0);
    chk("lost_width", 64'(o_lost), 64'd0);

    // Tie keeps the lower offset.
    do_reset();
    dl[0] = 64'd2; dl[1] = 64'd2; dl[2] = 64'd4; dl[3] = 64'd4;
    sweep_p4({$urandom, $urandom});

    // Counter wrap: offset 1 snapshots 2^64-3 and ends at 1.
    do_reset();
    dl[0] = 64'd6; dl[1] = 64'd4; dl[2] = 64'd9; dl[3] = 64'd8;
    sweep_p4(64'hFFFF_FFFF_FFFF_FFF7);
    chk("wrap_best_err", o_best_err, 64'd4);

    // Reset at the 5th window strobe of offset 1, with i_start pulsed throughout.
    do_reset();
    i_err_count = {$urandom, $urandom};
    cyc(1'b0, 1'b1);
    for (int s = 1; s <= 16; s++) begin
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
    end
    cyc(1'b0, 1'b1);
    chk("mid_offset", 64'(o_offset), 64'd1);
    chk("mid_busy", 64'(o_busy), 64'd1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    i_reset = 1'b1;
    cyc(1'b1, 1'b0);
    i_reset = 1'b0;
    chk_reset_vals("mid_reset");
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    chk("idle_rx_en", 64'(o_rx_enable), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);

    // Strobe accounting: a strobe on every clock, so one coincides with every state change.
    do_reset();
    dl[0] = 64'd3; dl[1] = 64'd1; dl[2] = 64'd1; dl[3] = 64'd2;
    i_err_count = {$urandom, $urandom};
    cyc(1'b1, 1'b1);
    for (int k = 1; k <= int'(OS * PH) + 2 * int'(WINDOW) + 2; k++) begin
      if (k <= int'(OS * PH) && ((k - 1) % PH) == 5) begin
        i_err_count = i_err_count + dl[(k - 1) / PH];
      end
      if (k == int'(OS * PH) + int'(WINDOW) + 4) i_err_count = i_err_count + 64'd1;
      cyc(1'b1, 1'($urandom));
      chk("acc_done", 64'(o_done), 64'(k == int'(OS * PH) + 1));
      chk("acc_locked", 64'(o_locked),
          64'(k >= int'(OS * PH) + 1 + int'(WINDOW) && k < int'(OS * PH) + 1 + 2 * int'(WINDOW)));
      chk("acc_lost", 64'(o_lost), 64'(k == int'(OS * PH) + 1 + 2 * int'(WINDOW)));
      if (k == int'(OS * PH) + 1) begin
        chk("acc_offset", 64'(o_offset), 64'd1);
        chk("acc_best_err", o_best_err, 64'd1);
      end
    end

    // Randomized sweeps with small deltas so ties are frequent.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < int'(OS); c++) dl[c] = 64'($urandom_range(0, 4));
      sweep_p4({$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
